// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM-stage slot, gates the register
// write enables, raises the overflow trap, counts loaded instructions and
// provides the combinational forwarding compare against the ID-stage sources.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32,
    parameter int NB = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          overflow,
    input  logic [DW-1:0] dout,
    input  logic [DW-1:0] result,
    input  logic [AW-1:0] rw,
    input  logic          regwr,
    input  logic [NB-1:0] byte_we,
    input  logic          memtoreg,
    input  logic          ovsel,
    input  logic [AW-1:0] rs_a,
    input  logic [AW-1:0] rs_b,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [AW-1:0] wb_rw,
    output logic          wb_we,
    output logic [NB-1:0] wb_byte_we,
    output logic          wb_ov_trap,
    output logic          fwd_a,
    output logic          fwd_b,
    output logic [CW-1:0] retired_cnt
);

    // Stage state
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic [AW-1:0] rw_q,    rw_d;
    logic          we_q,    we_d;
    logic [NB-1:0] bwe_q,   bwe_d;
    logic          trap_q,  trap_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Values the stage would take on a load edge
    logic          kill;
    logic          we_load;
    logic [NB-1:0] bwe_load;
    logic [DW-1:0] data_load;

    assign kill      = ovsel & overflow;
    assign we_load   = in_valid & regwr & ~kill & (rw != '0);
    assign data_load = memtoreg ? dout : result;

    // Lane enables only survive when the register write itself survives
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign bwe_load[gi] = byte_we[gi] & we_load;
        end
    endgenerate

    // Next-state selection: flush beats stall, stall beats load
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        rw_d    = rw_q;
        we_d    = we_q;
        bwe_d   = bwe_q;
        trap_d  = trap_q;
        cnt_d   = cnt_q;
        if (flush) begin
            // Bubble: the counter keeps its value since nothing was loaded
            valid_d = 1'b0;
            data_d  = '0;
            rw_d    = '0;
            we_d    = 1'b0;
            bwe_d   = '0;
            trap_d  = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            data_d  = data_load;
            rw_d    = rw;
            we_d    = we_load;
            bwe_d   = bwe_load;
            trap_d  = in_valid & kill;
            cnt_d   = cnt_q + CW'(in_valid);
        end
    end

    // State register with synchronous active-low reset taking precedence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rw_q    <= '0;
            we_q    <= 1'b0;
            bwe_q   <= '0;
            trap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            we_q    <= we_d;
            bwe_q   <= bwe_d;
            trap_q  <= trap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid    = valid_q;
    assign wb_data     = data_q;
    assign wb_rw       = rw_q;
    assign wb_we       = we_q;
    assign wb_byte_we  = bwe_q;
    assign wb_ov_trap  = trap_q;
    assign retired_cnt = cnt_q;

    // we_q is never set for r0, so the r0 guard here is belt and braces
    assign fwd_a = we_q & (rw_q != '0) & (rw_q == rs_a);
    assign fwd_b = we_q & (rw_q != '0) & (rw_q == rs_b);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each directed step queues its expected
// stage contents; a negedge monitor pops and compares them.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, in_valid, overflow, regwr, memtoreg, ovsel;
    logic [DW-1:0] dout, result;
    logic [AW-1:0] rw, rs_a, rs_b;
    logic [NB-1:0] byte_we;
    logic          wb_valid, wb_we, wb_ov_trap, fwd_a, fwd_b;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_rw;
    logic [NB-1:0] wb_byte_we;
    logic [CW-1:0] retired_cnt;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [AW-1:0] rw;
        logic          we;
        logic [NB-1:0] bwe;
        logic          trap;
        logic [CW-1:0] cnt;
        logic          fa;
        logic          fb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    mem_wb_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .overflow(overflow), .dout(dout), .result(result),
        .rw(rw), .regwr(regwr), .byte_we(byte_we), .memtoreg(memtoreg),
        .ovsel(ovsel), .rs_a(rs_a), .rs_b(rs_b),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rw(wb_rw), .wb_we(wb_we),
        .wb_byte_we(wb_byte_we), .wb_ov_trap(wb_ov_trap),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic v, logic [DW-1:0] d, logic [AW-1:0] r, logic we,
                                logic [NB-1:0] b, logic t, logic [CW-1:0] c,
                                logic fa, logic fb);
        exp_t e;
        e.valid = v; e.data = d; e.rw = r; e.we = we; e.bwe = b;
        e.trap = t; e.cnt = c; e.fa = fa; e.fb = fb;
        return e;
    endfunction

    task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s got %h want %h", step, name, got, want);
        end
    endtask

    // Monitor: compare the stage contents against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step++;
            chk("wb_valid",    DW'(wb_valid),    DW'(e.valid));
            chk("wb_data",     wb_data,          e.data);
            chk("wb_rw",       DW'(wb_rw),       DW'(e.rw));
            chk("wb_we",       DW'(wb_we),       DW'(e.we));
            chk("wb_byte_we",  DW'(wb_byte_we),  DW'(e.bwe));
            chk("wb_ov_trap",  DW'(wb_ov_trap),  DW'(e.trap));
            chk("retired_cnt", DW'(retired_cnt), DW'(e.cnt));
            chk("fwd_a",       DW'(fwd_a),       DW'(e.fa));
            chk("fwd_b",       DW'(fwd_b),       DW'(e.fb));
            $display("step %0d valid=%0b data=%h rw=%0d we=%0b bwe=%h trap=%0b cnt=%0d fa=%0b fb=%0b",
                     step, wb_valid, wb_data, wb_rw, wb_we, wb_byte_we, wb_ov_trap,
                     retired_cnt, fwd_a, fwd_b);
        end
    end

    // Queue the expectation for the coming edge, then move past the check
    task automatic go(exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Set up a plain valid register-writing load
    task automatic ld(logic [AW-1:0] r, logic [DW-1:0] res, logic [NB-1:0] b);
        rst_n = 1; stall = 0; flush = 0; in_valid = 1; regwr = 1;
        ovsel = 0; overflow = 0; memtoreg = 0; rw = r; result = res; byte_we = b;
    endtask

    initial begin
        // Watchdog: the run must never hang
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; stall = 1; flush = 1; in_valid = 1; overflow = 0; regwr = 1;
        memtoreg = 0; ovsel = 0; dout = 32'h1; result = 32'h2; rw = 5'd1;
        byte_we = 4'hF; rs_a = 5'd0; rs_b = 5'd0;
        // Reset overrides stall and flush
        go(mk(0, 32'h0, 0, 0, 4'h0, 0, 0, 0, 0));

        // Load from memory
        ld(5, 32'h1234, 4'hF); memtoreg = 1; dout = 32'hDEADBEEF; rs_a = 5; rs_b = 6;
        go(mk(1, 32'hDEADBEEF, 5, 1, 4'hF, 0, 1, 1, 0));

        // Overflow kill
        ld(3, 32'h11112222, 4'h3); ovsel = 1; overflow = 1; rs_a = 3; rs_b = 0;
        go(mk(1, 32'h11112222, 3, 0, 4'h0, 1, 2, 0, 0));
        // Same overflow, no trap selected
        ovsel = 0;
        go(mk(1, 32'h11112222, 3, 1, 4'h3, 0, 3, 1, 0));
        // Trap selected, no overflow
        ovsel = 1; overflow = 0; byte_we = 4'hC;
        go(mk(1, 32'h11112222, 3, 1, 4'hC, 0, 4, 1, 0));

        // Invalid slot: no write, no trap, counter holds
        ld(8, 32'hAAAA, 4'hF); in_valid = 0; ovsel = 1; overflow = 1; rs_a = 8;
        go(mk(0, 32'hAAAA, 8, 0, 4'h0, 0, 4, 0, 0));

        // Load rw=7, then stall three edges with different inputs
        ld(7, 32'h77, 4'hF); rs_a = 7; rs_b = 7;
        go(mk(1, 32'h77, 7, 1, 4'hF, 0, 5, 1, 1));
        ld(2, 32'h99, 4'h1); stall = 1;
        go(mk(1, 32'h77, 7, 1, 4'hF, 0, 5, 1, 1));
        go(mk(1, 32'h77, 7, 1, 4'hF, 0, 5, 1, 1));
        go(mk(1, 32'h77, 7, 1, 4'hF, 0, 5, 1, 1));
        // Flush wins over stall; counter untouched
        flush = 1;
        go(mk(0, 32'h0, 0, 0, 4'h0, 0, 5, 0, 0));
        // Flush alone
        ld(9, 32'h42, 4'hF); flush = 1;
        go(mk(0, 32'h0, 0, 0, 4'h0, 0, 5, 0, 0));

        // Forwarding
        ld(9, 32'h9, 4'h5); rs_a = 9; rs_b = 4;
        go(mk(1, 32'h9, 9, 1, 4'h5, 0, 6, 1, 0));
        ld(0, 32'h5, 4'hF); rs_a = 0; rs_b = 0;
        go(mk(1, 32'h5, 0, 0, 4'h0, 0, 7, 0, 0));
        ld(9, 32'h6, 4'hF); regwr = 0; rs_a = 9; rs_b = 9;
        go(mk(1, 32'h6, 9, 0, 4'h0, 0, 8, 0, 0));

        // Eight more valid loads wrap the 4-bit counter back to 0
        for (int i = 1; i <= 8; i++) begin
            ld(AW'(i + 10), DW'(i), 4'hF); rs_a = AW'(i + 10); rs_b = 0;
            go(mk(1, DW'(i), AW'(i + 10), 1, 4'hF, 0, CW'((8 + i) % 16), 1, 0));
        end

        // Reset during a stall discards the held instruction
        ld(4, 32'h44, 4'hF); rs_a = 4; rs_b = 4;
        go(mk(1, 32'h44, 4, 1, 4'hF, 0, 1, 1, 1));
        stall = 1; rst_n = 0;
        go(mk(0, 32'h0, 0, 0, 4'h0, 0, 0, 0, 0));

        // First load after reset
        ld(6, 32'h0, 4'h8); memtoreg = 1; dout = 32'hCAFEF00D; rs_a = 1; rs_b = 6;
        go(mk(1, 32'hCAFEF00D, 6, 1, 4'h8, 0, 1, 0, 1));

        // Let the monitor drain, bounded
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
